// File: rtl/riscv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings and FSM states.
package riscv_mdu_pkg;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and shift the resulting quotient bit in at the bottom.
module mdu_div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic [31:0] quo_o
);

   logic [32:0] shifted;
   logic [32:0] trial;
   logic        fits;

   // The partial remainder is always below 2*divisor, so bit 32 of the 33-bit trial is a clean borrow.
   assign shifted = {rem_i, quo_i[31]};
   assign trial   = shifted - {1'b0, divisor_i};
   assign fits    = ~trial[32];
   assign rem_o   = fits ? trial[31:0] : shifted[31:0];
   assign quo_o   = {quo_i[30:0], fits};

endmodule

// File: rtl/mdu_riscv.sv
// RV32M multiply/divide unit: 2-cycle registered multiplier and 1-bit/cycle restoring divider
// behind a small IDLE/MUL/DIV/DONE controller that stalls the pipeline while busy.
module mdu_riscv
   import riscv_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            kill_i,
   output logic            stall_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   mdu_state_t state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] opa_q, opa_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            quo_neg_q, quo_neg_d;
   logic            rem_neg_q, rem_neg_d;

   logic            accept;
   logic            div_signed;
   logic            a_sext;
   logic            b_sext;
   logic [63:0]     a_wide;
   logic [63:0]     b_wide;
   logic [63:0]     prod;
   logic [XLEN-1:0] step_rem;
   logic [XLEN-1:0] step_quo;

   assign accept     = (state_q == IDLE) && start_i && !kill_i;
   assign div_signed = ~op_i[0];

   // 33x33 signed product, carried in 64 bits: the low 64 bits are all any RV32M op needs.
   assign a_sext = (op_q != MDU_MULHU) & opa_q[31];
   assign b_sext = ((op_q == MDU_MUL) || (op_q == MDU_MULH)) & opb_q[31];
   assign a_wide = {{32{a_sext}}, opa_q};
   assign b_wide = {{32{b_sext}}, opb_q};
   assign prod   = a_wide * b_wide;

   mdu_div_step u_div_step (
      .rem_i     (rem_q),
      .quo_i     (opa_q),
      .divisor_i (opb_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      rem_d     = rem_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d = op_i;
               if (!op_i[2]) begin
                  opa_d   = rs1_i;
                  opb_d   = rs2_i;
                  state_d = MUL;
               end else if (rs2_i == '0) begin
                  result_d = op_i[1] ? rs1_i : '1;
                  state_d  = DONE;
               end else if (div_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF)) begin
                  result_d = op_i[1] ? '0 : 32'h8000_0000;
                  state_d  = DONE;
               end else begin
                  // Divide magnitudes; signs are restored after the last iteration.
                  opa_d     = (div_signed && rs1_i[31]) ? -rs1_i : rs1_i;
                  opb_d     = (div_signed && rs2_i[31]) ? -rs2_i : rs2_i;
                  rem_d     = '0;
                  cnt_d     = 5'd31;
                  quo_neg_d = div_signed & (rs1_i[31] ^ rs2_i[31]);
                  rem_neg_d = div_signed & rs1_i[31];
                  state_d   = DIV;
               end
            end
         end
         MUL: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               result_d = (op_q == MDU_MUL) ? prod[31:0] : prod[63:32];
               state_d  = DONE;
            end
         end
         DIV: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               opa_d = step_quo;
               rem_d = step_rem;
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  if (op_q[1]) begin
                     result_d = rem_neg_q ? -step_rem : step_rem;
                  end else begin
                     result_d = quo_neg_q ? -step_quo : step_quo;
                  end
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rem_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         rem_q     <= rem_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
      end
   end

   assign stall_o  = accept || (state_q == MUL) || (state_q == DIV);
   assign valid_o  = (state_q == DONE);
   assign result_o = (state_q == DONE) ? result_q : '0;

endmodule

// File: tb/tb_mdu_riscv.sv
// Self-checking bench for mdu_riscv: directed corner cases plus randomized ops against an
// arithmetic reference model of the RV32M results and their issue-to-valid latency.
module tb_mdu_riscv;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        kill;
   logic        stall_o;
   logic        valid_o;
   logic [31:0] result_o;

   int compared   = 0;
   int mismatched = 0;

   mdu_riscv #(.XLEN(32)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .op_i     (op),
      .rs1_i    (rs1),
      .rs2_i    (rs2),
      .kill_i   (kill),
      .stall_o  (stall_o),
      .valid_o  (valid_o),
      .result_o (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      longint p;
      logic   ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3 < 3'd4) return 2;
      if (b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
      end
   endtask

   // Issue one operation in cycle N and follow it to its valid pulse (bounded wait).
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp_r;
      int          exp_lat;
      int          lat;
      exp_r   = ref_result(f3, a, b);
      exp_lat = ref_latency(f3, a, b);
      @(negedge clk);
      start = 1'b1; op = f3; rs1 = a; rs2 = b;
      #1 check("stall_accept", {31'b0, stall_o}, 32'd1);
      @(negedge clk);
      start = 1'b0; rs1 = $urandom; rs2 = $urandom;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 40) begin
         check("stall_busy", {31'b0, stall_o}, 32'd1);
         check("result_gated", result_o, 32'd0);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, exp_lat);
      check("result", result_o, exp_r);
      check("stall_done", {31'b0, stall_o}, 32'd0);
      $display("op=%0d rs1=%08h rs2=%08h result=%08h expected=%08h latency=%0d", f3, a, b, result_o, exp_r, lat);
      @(negedge clk);
      check("valid_single", {31'b0, valid_o}, 32'd0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          mode;

      rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;
      #12;
      check("reset_stall", {31'b0, stall_o}, 32'd0);
      check("reset_valid", {31'b0, valid_o}, 32'd0);
      check("reset_result", result_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
      run_op(3'd2, 32'h8000_0000, 32'h8000_0000);
      run_op(3'd3, 32'h8000_0000, 32'h8000_0000);
      run_op(3'd4, 32'hFFFF_FFEC, 32'd3);
      run_op(3'd6, 32'hFFFF_FFEC, 32'd3);
      run_op(3'd5, 32'd100, 32'd0);
      run_op(3'd7, 32'd100, 32'd0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      // kill_i in IDLE blocks acceptance
      @(negedge clk);
      start = 1'b1; kill = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
      #1 check("kill_idle_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("kill_idle_state", {31'b0, stall_o}, 32'd0);
      check("kill_idle_valid", {31'b0, valid_o}, 32'd0);

      // DIVU killed at N+10
      @(negedge clk);
      start = 1'b1; op = 3'd5; rs1 = 32'hFFFF_FFFF; rs2 = 32'd16;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      #1 check("kill_div_stall", {31'b0, stall_o}, 32'd1);
      @(negedge clk);
      kill = 1'b0;
      #1 check("kill_div_idle", {31'b0, stall_o}, 32'd0);
      check("kill_div_valid", {31'b0, valid_o}, 32'd0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("kill_no_valid", {31'b0, valid_o}, 32'd0);
      end
      $display("op=5 rs1=ffffffff rs2=00000010 killed at N+10");
      run_op(3'd0, 32'd6, 32'd7);

      // kill during MUL
      @(negedge clk);
      start = 1'b1; op = 3'd1; rs1 = 32'd9; rs2 = 32'd9;
      @(negedge clk);
      start = 1'b0; kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_mul_valid", {31'b0, valid_o}, 32'd0);
      check("kill_mul_stall", {31'b0, stall_o}, 32'd0);
      $display("op=1 rs1=00000009 rs2=00000009 killed at N+1");

      // async reset at N+5 of a DIV
      @(negedge clk);
      start = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_reset_stall", {31'b0, stall_o}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midreset_stall", {31'b0, stall_o}, 32'd0);
      check("midreset_valid", {31'b0, valid_o}, 32'd0);
      check("midreset_result", result_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_valid", {31'b0, valid_o}, 32'd0);
      end
      $display("op=4 rs1=000003e8 rs2=00000007 reset at N+5");
      run_op(3'd7, 32'd17, 32'd5);

      for (int i = 0; i < 30; i++) begin
         rop  = 3'($urandom_range(0, 7));
         ra   = $urandom;
         rb   = $urandom;
         mode = $urandom_range(0, 9);
         if (mode == 0) rb = 32'd0;
         else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         else if (mode == 2) begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
         else if (mode == 3) rb = -32'($urandom_range(1, 20));
         run_op(rop, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
